sp_series_proc: RTL and testbench
=================================

Name: sp_series_proc

Overview:
- Parametrised successor to the team's 9-bit, 3-mode series processor.
- Accepts a burst of N signed samples plus a 3-bit mode word, then runs up to three selectable processing stages: Gray decode, saturating prefix sum and trailing moving average.
- Streams the N results back out.
- Includes an optional clock-gating enable (cg_en) for the low-power flow; gating must never change the functional result.

Parameters:
DW, 9, sample width in bits (signed two's complement after decode), DW >= 4
N, 6, samples per burst, N >= 3
WIN, 3, moving-average window length, 2 <= WIN <= N

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
cg_en  input  1  1 = clock gating of idle registers enabled; changes only while idle
in_valid  input  1  high for exactly N consecutive cycles per burst
in_data  input  DW  sample, one per in_valid cycle
in_mode  input  3  mode word, valid only on the first in_valid cycle of a burst
out_valid  output  1  high for exactly N consecutive cycles per result burst
out_data  output  DW  result sample, 0 whenever out_valid is low

Behaviour:
- Reset: asynchronous, active-low. out_valid=0, out_data=0, FSM to IDLE, sample buffer, mode register and counters cleared. Applies immediately, including mid-burst or mid-output.
- FSM states: IDLE -> LOAD -> CALC -> OUT -> IDLE.
- IDLE:
  - in_valid=1 moves the FSM to LOAD.
  - On that same first cycle, in_mode is latched and sample 0 is stored.
- LOAD:
  - One sample is stored per in_valid cycle.
  - After N samples, the FSM goes to CALC.
- Protocol violations:
  - in_valid in CALC or OUT is ignored.
  - in_valid dropping before N samples is a protocol violation; behaviour is undefined and is not checked.
- CALC: exactly 3 cycles, one per stage, in fixed order.
  - A disabled stage passes data through unchanged.
  - A disabled stage is clock-gated when cg_en=1.
- Stage 1, mode[0], Gray decode per sample: b[DW-1]=g[DW-1]; b[i]=b[i+1]^g[i].
- Stage 2, mode[1], saturating prefix sum:
  - s[0]=x[0]; s[i]=sat(s[i-1]+x[i]).
  - sat clamps to [-2^(DW-1), 2^(DW-1)-1].
  - The running sum continues from the saturated value.
- Stage 3, mode[2], trailing moving average:
  - y[i] = (sum of x[max(0,i-WIN+1)..i]) / count, where count = min(i+1, WIN).
  - Internal sum width is DW+ceil(log2 WIN) bits.
  - Signed division truncates toward zero. The result always fits in DW bits.
- Latency:
  - If the last in_valid cycle is L, CALC occupies cycles L+1..L+3.
  - out_valid is high on cycles L+4..L+3+N, with results in index order 0..N-1.
- Return to IDLE: after the last output cycle the FSM returns to IDLE, and a new burst may start on the very next cycle.
- Clock gating:
  - With cg_en=1, the sample buffer is enabled only in LOAD and in CALC stages that are active.
  - The output register is enabled only in OUT and on its exit.
  - Outputs must be bit-identical for cg_en=0 and cg_en=1.

Test Plan:
- Mode 000: inputs 1,2,3,4,5,6 -> out 1,2,3,4,5,6; first out_valid exactly 4 cycles after the last in_valid cycle; out_valid high 6 cycles; out_data=0 otherwise.
- Mode 001: inputs 0x003,0x002,0x006,0x007,0x005,0x004 -> out 2,3,4,5,6,7. Separately, input 0x100 -> out 0x1FF (-1).
- Mode 010: inputs 100,100,100,-50,-200,-200 -> out 100,200,255,205,5,-195 (positive saturation at index 2, running sum continues from 255).
- Mode 100: inputs 3,6,9,-3,-4,0 -> out 3,4,6,4,0,-2 (0x1FE).
- Reset mid-operation: pull rst_n low during the 3rd output cycle -> out_valid and out_data are 0 in the same cycle. After release, a mode-000 burst of 7,7,7,7,7,7 returns 7×6 with normal latency.
- Clock-gating equivalence:
  - Random bursts run back-to-back, all 8 modes including 111 (order decode -> sum -> average), with cg_en=0 and again with cg_en=1.
  - Both runs are compared cycle-by-cycle against each other and against the reference model: zero mismatches.
  - Back-to-back bursts are also accepted with no gap.

Source files
------------

// File: rtl/sp_series_proc.sv
`default_nettype none
// ============================================================================
// Module  : sp_series_proc
// Brief   : Burst series processor. Captures N signed samples and a mode word,
//           runs Gray decode, saturating prefix sum and trailing moving
//           average (each selectable), then streams the N results out.
// Revision: 1.0 - parametrised successor of the 9-bit 3-mode processor
// ============================================================================
module sp_series_proc #(
  parameter int DW  = 9,
  parameter int N   = 6,
  parameter int WIN = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cg_en,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic [2:0]    in_mode,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);

  localparam int c_CW    = $clog2(N);
  localparam int c_SUM_W = DW + $clog2(WIN);
  localparam logic [c_CW-1:0] c_LAST     = c_CW'(N - 1);
  localparam logic [c_CW-1:0] c_STG_LAST = c_CW'(2);
  localparam logic [DW-1:0]   c_SMAX     = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0]   c_SMIN     = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CALC = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [c_CW-1:0]           r_cnt;      // sample index in LOAD, stage in CALC, output index in OUT
  logic [2:0]                r_mode;
  logic [DW-1:0]             r_buf [N];
  logic                      r_out_valid;
  logic [DW-1:0]             r_out_data;

  logic [DW-1:0]             w_gray  [N];
  logic [DW-1:0]             w_psum  [N];
  logic [DW-1:0]             w_mavg  [N];
  logic [DW-1:0]             w_stage_out [N];
  logic                      w_stage_act;
  logic [DW-1:0]             w_run;
  logic [DW:0]               w_psum_ext;
  logic signed [c_SUM_W-1:0] w_acc;
  logic signed [c_SUM_W-1:0] w_div;
  logic                      w_load_en;
  logic [c_CW-1:0]           w_wr_idx;
  logic                      w_out_en;
  logic                      w_out_valid_d;
  logic [DW-1:0]             w_out_data_d;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state: IDLE -> LOAD -> CALC (3 cycles) -> OUT (N cycles) -> IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_state_nxt = S_LOAD;
      S_LOAD:  if (in_valid && (r_cnt == c_LAST)) w_state_nxt = S_CALC;
      S_CALC:  if (r_cnt == c_STG_LAST) w_state_nxt = S_OUT;
      S_OUT:   if (r_cnt == c_LAST) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Shared counter and mode latch (mode is sampled only on the first sample)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_mode <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_mode <= in_mode;
          r_cnt  <= c_CW'(1);
        end
        S_LOAD: if (in_valid) r_cnt <= (r_cnt == c_LAST) ? '0 : r_cnt + 1'b1;
        S_CALC: r_cnt <= (r_cnt == c_STG_LAST) ? '0 : r_cnt + 1'b1;
        S_OUT:  r_cnt <= (r_cnt == c_LAST) ? '0 : r_cnt + 1'b1;
        default: r_cnt <= '0;
      endcase
    end
  end

  // Gray decode: each binary bit is the XOR of all Gray bits at or above it
  always_comb begin
    for (int n = 0; n < N; n++) begin
      w_gray[n] = '0;
      for (int b = 0; b < DW; b++) w_gray[n][b] = ^(r_buf[n] >> b);
    end
  end

  // Saturating prefix sum; the running value restarts from the clamped sum
  always_comb begin
    w_psum_ext = '0;
    w_run      = r_buf[0];
    w_psum[0]  = r_buf[0];
    for (int n = 1; n < N; n++) begin
      w_psum_ext = {w_run[DW-1], w_run} + {r_buf[n][DW-1], r_buf[n]};
      if (w_psum_ext[DW] != w_psum_ext[DW-1]) w_run = w_psum_ext[DW] ? c_SMIN : c_SMAX;
      else                                    w_run = w_psum_ext[DW-1:0];
      w_psum[n] = w_run;
    end
  end

  // Trailing moving average; short windows at the start divide by fewer terms
  always_comb begin
    w_acc = '0;
    w_div = '0;
    for (int n = 0; n < N; n++) begin
      w_acc = '0;
      for (int k = 0; k < WIN; k++) begin
        if (n >= k)
          w_acc = w_acc + {{(c_SUM_W-DW){r_buf[(n >= k) ? n - k : 0][DW-1]}},
                           r_buf[(n >= k) ? n - k : 0]};
      end
      w_div     = (n + 1 < WIN) ? c_SUM_W'(n + 1) : c_SUM_W'(WIN);
      w_mavg[n] = DW'(w_acc / w_div);
    end
  end

  // Stage selection for the current CALC cycle; disabled stages pass through
  always_comb begin
    w_stage_act = 1'b0;
    w_stage_out = r_buf;
    if (r_state == S_CALC) begin
      case (r_cnt)
        c_CW'(0): begin w_stage_act = r_mode[0]; if (r_mode[0]) w_stage_out = w_gray; end
        c_CW'(1): begin w_stage_act = r_mode[1]; if (r_mode[1]) w_stage_out = w_psum; end
        c_CW'(2): begin w_stage_act = r_mode[2]; if (r_mode[2]) w_stage_out = w_mavg; end
        default:  w_stage_act = 1'b0;
      endcase
    end
  end

  assign w_load_en = in_valid && ((r_state == S_IDLE) || (r_state == S_LOAD));
  assign w_wr_idx  = (r_state == S_IDLE) ? '0 : r_cnt;

  // Sample buffer: capture in LOAD, rewrite in CALC (idle stages held when gated)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) r_buf[i] <= '0;
    end else if (w_load_en) begin
      r_buf[w_wr_idx] <= in_data;
    end else if ((r_state == S_CALC) && (w_stage_act || !cg_en)) begin
      r_buf <= w_stage_out;
    end
  end

  // Output next values: result 0 comes straight from the last stage
  always_comb begin
    w_out_valid_d = 1'b0;
    w_out_data_d  = '0;
    if ((r_state == S_CALC) && (r_cnt == c_STG_LAST)) begin
      w_out_valid_d = 1'b1;
      w_out_data_d  = w_stage_out[0];
    end else if ((r_state == S_OUT) && (r_cnt != c_LAST)) begin
      w_out_valid_d = 1'b1;
      w_out_data_d  = r_buf[r_cnt + 1'b1];
    end
  end

  assign w_out_en = !cg_en || (r_state == S_OUT) ||
                    ((r_state == S_CALC) && (r_cnt == c_STG_LAST));

  // Output register; outside its enable window it already holds zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_out_en) begin
      r_out_valid <= w_out_valid_d;
      r_out_data  <= w_out_data_d;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_sp_series_proc.sv
`default_nettype none
// ============================================================================
// Module  : tb_sp_series_proc
// Brief   : Self-checking bench for sp_series_proc with a behavioural model,
//           directed vectors, reset abort and clock-gating equivalence.
// Revision: 1.0
// ============================================================================
module tb_sp_series_proc;

  localparam int DW  = 9;
  localparam int N   = 6;
  localparam int WIN = 3;
  localparam int NB  = 24;

  typedef logic [DW-1:0] vec_t [N];

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cg_en;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [2:0]    in_mode;
  logic          out_valid;
  logic [DW-1:0] out_data;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int first_valid;
  int vcount;
  bit rec = 1'b0;
  int run_sel = 0;
  logic [DW-1:0] exp_map [int];
  int trace0 [$];
  int trace1 [$];

  logic [2:0] r_modes [NB];
  vec_t       r_smps  [NB];
  int         r_gaps  [NB];

  sp_series_proc #(.DW(DW), .N(N), .WIN(WIN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cg_en     (cg_en),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  // Cycle index: cycle k spans posedge k to posedge k+1
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer arithmetic straight from the stage definitions
  function automatic void model(input logic [2:0] mode, input vec_t x, output vec_t y);
    int v [N];
    int w [N];
    int mx, mn, g, b, t, sum, cnt;
    mx = 2 ** (DW - 1) - 1;
    mn = -(2 ** (DW - 1));
    for (int i = 0; i < N; i++) begin
      g = int'(x[i]);
      if (mode[0]) begin
        b = g; t = g >> 1;
        while (t != 0) begin b = b ^ t; t = t >> 1; end
        g = b;
      end
      v[i] = (g > mx) ? g - 2 ** DW : g;
    end
    if (mode[1]) begin
      for (int i = 1; i < N; i++) begin
        v[i] = v[i-1] + v[i];
        if (v[i] > mx) v[i] = mx;
        if (v[i] < mn) v[i] = mn;
      end
    end
    if (mode[2]) begin
      for (int i = 0; i < N; i++) w[i] = v[i];
      for (int i = 0; i < N; i++) begin
        sum = 0; cnt = 0;
        for (int k = 0; k < WIN && i - k >= 0; k++) begin
          sum += w[i-k]; cnt++;
        end
        v[i] = sum / cnt;
      end
    end
    for (int i = 0; i < N; i++) y[i] = DW'(v[i]);
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Per-cycle compare of the DUT outputs against the scheduled expectations
  task automatic check_cycle();
    logic          ev;
    logic [DW-1:0] ed;
    ev = (exp_map.exists(cyc) != 0);
    ed = ev ? exp_map[cyc] : '0;
    check($sformatf("cycle %0d {out_valid,out_data}", cyc),
          int'({out_valid, out_data}), int'({ev, ed}));
    if (ev) exp_map.delete(cyc);
    if (out_valid === 1'b1) begin
      vcount++;
      if (first_valid < 0) first_valid = cyc;
    end
    if (rec) begin
      if (run_sel == 0) trace0.push_back(int'({out_valid, out_data}));
      else              trace1.push_back(int'({out_valid, out_data}));
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_burst(input logic [2:0] mode, input vec_t smp, output int last);
    vec_t y;
    model(mode, smp, y);
    last = 0;
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1;
      in_data  = smp[i];
      in_mode  = (i == 0) ? mode : 3'($urandom);
      if (i == N - 1) last = cyc;
      step();
    end
    for (int j = 0; j < N; j++) exp_map[last + 4 + j] = y[j];
    in_valid = 1'b0;
    in_data  = DW'($urandom);
    in_mode  = 3'($urandom);
  endtask

  task automatic send(input logic [2:0] mode, input vec_t smp, input int gap, input bit chk_lat);
    int last;
    first_valid = -1;
    vcount      = 0;
    drive_burst(mode, smp, last);
    repeat (N + 3 + gap) step();
    if (chk_lat) begin
      check($sformatf("mode %0b latency", mode), first_valid - last, 4);
      check($sformatf("mode %0b out_valid length", mode), vcount, N);
    end
  endtask

  task automatic pin(input string name, input logic [2:0] mode, input vec_t x, input vec_t req);
    vec_t y;
    model(mode, x, y);
    for (int i = 0; i < N; i++)
      check($sformatf("model %s [%0d]", name, i), int'(y[i]), int'(req[i]));
  endtask

  function automatic logic [DW-1:0] rand_sample();
    case ($urandom_range(0, 3))
      0:       return {1'b0, {(DW-1){1'b1}}};
      1:       return {1'b1, {(DW-1){1'b0}}};
      default: return DW'($urandom);
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v_cnt, v_gry, v_msb, v_sat, v_avg, v_sev, r;
    int   last;

    rst_n    = 1'b0;
    cg_en    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_mode  = '0;

    v_cnt = '{9'd1, 9'd2, 9'd3, 9'd4, 9'd5, 9'd6};
    v_gry = '{9'h003, 9'h002, 9'h006, 9'h007, 9'h005, 9'h004};
    v_msb = '{9'h100, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000};
    v_sat = '{9'd100, 9'd100, 9'd100, 9'h1CE, 9'h138, 9'h138};
    v_avg = '{9'd3, 9'd6, 9'd9, 9'h1FD, 9'h1FC, 9'd0};
    v_sev = '{9'd7, 9'd7, 9'd7, 9'd7, 9'd7, 9'd7};

    // Hand-computed expectations that pin the reference model
    pin("mode000", 3'b000, v_cnt, v_cnt);
    r = '{9'd2, 9'd3, 9'd4, 9'd5, 9'd6, 9'd7};
    pin("mode001", 3'b001, v_gry, r);
    r = '{9'h1FF, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0};
    pin("mode001 msb", 3'b001, v_msb, r);
    r = '{9'd100, 9'd200, 9'd255, 9'd205, 9'd5, 9'h13D};
    pin("mode010", 3'b010, v_sat, r);
    r = '{9'd3, 9'd4, 9'd6, 9'd4, 9'd0, 9'h1FE};
    pin("mode100", 3'b100, v_avg, r);
    r = '{9'd2, 9'd3, 9'd5, 9'd9, 9'd14, 9'd20};
    pin("mode111", 3'b111, v_gry, r);

    // Reset state
    repeat (2) step();
    check("reset state {out_valid,out_data}", int'({out_valid, out_data}), 0);
    rst_n = 1'b1;
    step();

    // Directed bursts through the DUT
    send(3'b000, v_cnt, 0, 1'b1);
    send(3'b001, v_gry, 0, 1'b1);
    send(3'b001, v_msb, 0, 1'b1);
    send(3'b010, v_sat, 0, 1'b1);
    send(3'b100, v_avg, 2, 1'b1);

    // Reset during the third output cycle
    drive_burst(3'b000, v_cnt, last);
    while (cyc < last + 6) step();
    #1 rst_n = 1'b0;
    #1 check("reset mid-output {out_valid,out_data}", int'({out_valid, out_data}), 0);
    exp_map.delete();
    repeat (2) step();
    rst_n = 1'b1;
    step();
    send(3'b000, v_sev, 0, 1'b1);

    // Random back-to-back bursts, run with gating off then on
    for (int b = 0; b < NB; b++) begin
      r_modes[b] = (b < 8) ? 3'(b) : 3'($urandom);
      for (int i = 0; i < N; i++) r_smps[b][i] = rand_sample();
      r_gaps[b] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
    end
    for (int run = 0; run < 2; run++) begin
      cg_en   = (run == 1);
      run_sel = run;
      rec     = 1'b1;
      for (int b = 0; b < NB; b++) send(r_modes[b], r_smps[b], r_gaps[b], 1'b0);
      rec     = 1'b0;
    end

    check("cg trace length", trace1.size(), trace0.size());
    for (int i = 0; i < trace0.size() && i < trace1.size(); i++)
      check($sformatf("cg_en=1 vs cg_en=0 trace[%0d]", i), trace1[i], trace0[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
